// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: shared state encoding and run-mode constants for cnt_sequencer.
// Build option CNT_SEQ_PRESCALE_EN is consumed by the interface, top and prescaler files.
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/cnt_sequencer_if.sv
// cnt_sequencer_if: command inputs and counter status of cnt_sequencer; presc_div and
// PRESC_W exist only when CNT_SEQ_PRESCALE_EN is defined.
interface cnt_sequencer_if #(
  parameter int WIDTH = 4
`ifdef CNT_SEQ_PRESCALE_EN
  , parameter int PRESC_W = 4
`endif
);

  logic             start;
  logic             stop;
  logic             clear;
  logic             mode;
  logic [WIDTH-1:0] load_val;
`ifdef CNT_SEQ_PRESCALE_EN
  logic [PRESC_W-1:0] presc_div;
`endif
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             tick;
  logic             done;

`ifdef CNT_SEQ_PRESCALE_EN
  modport master (output start, stop, clear, mode, load_val, presc_div,
                  input  cnt, busy, tick, done);
  modport slave  (input  start, stop, clear, mode, load_val, presc_div,
                  output cnt, busy, tick, done);
`else
  modport master (output start, stop, clear, mode, load_val,
                  input  cnt, busy, tick, done);
  modport slave  (input  start, stop, clear, mode, load_val,
                  output cnt, busy, tick, done);
`endif

endinterface

// File: rtl/cnt_seq_presc.sv
// cnt_seq_presc: divide-by-(div+1) enable for the RUN counter; en is combinational from the held count.
// Latency: en rises the cycle the count equals div; no backpressure, clr wins over run.
module cnt_seq_presc #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               run,
  input  logic [PRESC_W-1:0] div,
  output logic               en
);

  logic [PRESC_W-1:0] presc_q;

  assign en = run && (presc_q == div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc_q <= '0;
    end else if (run) begin
      presc_q <= (presc_q == div) ? '0 : presc_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/cnt_sequencer.sv
// cnt_sequencer: start/stop/clear run control over an up-counter with terminal-count tick; tick/done are
// registered one edge after the terminal count; no backpressure. Prescaler enable via CNT_SEQ_PRESCALE_EN.
module cnt_sequencer #(
  parameter int WIDTH = 4
`ifdef CNT_SEQ_PRESCALE_EN
  , parameter int PRESC_W = 4
`endif
) (
  input  logic            clk,
  input  logic            rst,
  cnt_sequencer_if.slave  sif
);

  import cnt_seq_pkg::*;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             en;

`ifdef CNT_SEQ_PRESCALE_EN
  logic presc_clr;
  logic presc_run;

  // Prescaler only advances on RUN cycles that actually count, so stop and clear freeze it.
  assign presc_clr = sif.clear || (sif.start && (state_q == IDLE || state_q == DONE));
  assign presc_run = (state_q == RUN) && !sif.stop && !sif.clear;

  cnt_seq_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (presc_clr),
    .run (presc_run),
    .div (sif.presc_div),
    .en  (en)
  );
`else
  assign en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    term_d  = term_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    if (sif.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (sif.start) begin
            state_d = RUN;
            term_d  = sif.load_val;
            mode_d  = sif.mode;
            cnt_d   = '0;
          end
        end
        RUN: begin
          if (sif.stop) begin
            state_d = PAUSE;
          end else if (en) begin
            if (cnt_q == term_q) begin
              tick_d = 1'b1;
              if (mode_q == MODE_ONESHOT) state_d = DONE;
              else                        cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end
        end
        PAUSE: begin
          if (sif.start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      term_q  <= '0;
      mode_q  <= MODE_ONESHOT;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
    end
  end

  assign sif.cnt  = cnt_q;
  assign sif.busy = (state_q == RUN) || (state_q == PAUSE);
  assign sif.done = (state_q == DONE);
  assign sif.tick = tick_q;

endmodule

// File: tb/tb_cnt_sequencer.sv
// tb_cnt_sequencer: table of {controls, expected cnt/busy/tick/done} vectors fed through a
// one-deep expectation queue, plus a measured tick period with a bounded wait.
module tb_cnt_sequencer;

  localparam int W  = 4;
  localparam int PW = 4;

  // ctl bits {rst, start, stop, clear, mode}
  localparam logic [4:0] C_RST   = 5'b10000;
  localparam logic [4:0] C_START = 5'b01000;
  localparam logic [4:0] C_STOP  = 5'b00100;
  localparam logic [4:0] C_CLR   = 5'b00010;
  localparam logic [4:0] C_PER   = 5'b00001;
  // expected {busy, tick, done}
  localparam logic [2:0] O_IDLE  = 3'b000;
  localparam logic [2:0] O_RUN   = 3'b100;
  localparam logic [2:0] O_RTICK = 3'b110;
  localparam logic [2:0] O_DTICK = 3'b011;
  localparam logic [2:0] O_DONE  = 3'b001;

  typedef struct {
    int         id;
    logic [4:0] ctl;
    logic [3:0] ld;
    logic [3:0] pd;
    logic [3:0] ec;
    logic [2:0] bte;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef CNT_SEQ_PRESCALE_EN
  cnt_sequencer_if #(.WIDTH(W), .PRESC_W(PW)) bus ();
  cnt_sequencer    #(.WIDTH(W), .PRESC_W(PW)) dut (.clk(clk), .rst(rst), .sif(bus.slave));
`else
  cnt_sequencer_if #(.WIDTH(W)) bus ();
  cnt_sequencer    #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .sif(bus.slave));
`endif

  vec_t       vecs[$];
  logic [6:0] exp_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  function automatic void add(int id, logic [4:0] ctl, logic [3:0] ld, logic [3:0] pd,
                              logic [3:0] ec, logic [2:0] bte);
    vec_t v;
    v.id = id; v.ctl = ctl; v.ld = ld; v.pd = pd; v.ec = ec; v.bte = bte;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic [4:0] ctl, logic [3:0] ld, logic [3:0] pd);
    {rst, bus.start, bus.stop, bus.clear, bus.mode} = ctl;
    bus.load_val = ld;
`ifdef CNT_SEQ_PRESCALE_EN
    bus.presc_div = pd;
`endif
  endtask

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin
    logic [6:0] act;
    logic [6:0] exp;
    int tk[3];
    int ntk;

    // 1: reset held, start ignored under rst
    add(1, C_RST, 0, 0, 0, O_IDLE);
    add(1, C_RST, 0, 0, 0, O_IDLE);
    add(1, C_RST | C_START | C_PER, 3, 0, 0, O_IDLE);
    // 2: periodic term 3; start mid-run and load_val changes ignored
    add(2, C_START | C_PER, 3, 0, 0, O_RUN);
    for (int k = 1; k <= 8; k++)
      add(2, (k == 2) ? C_START : 5'b0, 4'd7, 0, 4'(k % 4), (k % 4 == 0) ? O_RTICK : O_RUN);
    add(2, C_CLR, 0, 0, 0, O_IDLE);
    // 3: one-shot term 5, stop in DONE ignored, re-arm
    add(3, C_START, 5, 0, 0, O_RUN);
    for (int k = 1; k <= 5; k++) add(3, 0, 9, 0, 4'(k), O_RUN);
    add(3, 0, 9, 0, 5, O_DTICK);
    add(3, 0, 0, 0, 5, O_DONE);
    add(3, C_STOP, 0, 0, 5, O_DONE);
    add(3, C_START, 5, 0, 0, O_RUN);
    add(3, 0, 0, 0, 1, O_RUN);
    add(3, C_CLR, 0, 0, 0, O_IDLE);
    // 4: pause/resume, stop beats start, clear beats start
    add(4, C_START | C_PER, 9, 0, 0, O_RUN);
    for (int k = 1; k <= 4; k++) add(4, 0, 9, 0, 4'(k), O_RUN);
    add(4, C_STOP, 9, 0, 4, O_RUN);
    for (int k = 0; k < 4; k++) add(4, 0, 9, 0, 4, O_RUN);
    add(4, C_START, 2, 0, 4, O_RUN);
    add(4, 0, 2, 0, 5, O_RUN);
    add(4, 0, 2, 0, 6, O_RUN);
    add(4, C_STOP | C_START, 0, 0, 6, O_RUN);
    add(4, 0, 0, 0, 6, O_RUN);
    add(4, C_CLR | C_START | C_PER, 3, 0, 0, O_IDLE);
    add(4, 0, 0, 0, 0, O_IDLE);
    // 5: term 0 periodic and one-shot, term 15 wrap, rst mid-run
    add(5, C_START | C_PER, 0, 0, 0, O_RUN);
    for (int k = 0; k < 4; k++) add(5, 0, 0, 0, 0, O_RTICK);
    add(5, C_STOP, 0, 0, 0, O_RUN);
    add(5, C_CLR, 0, 0, 0, O_IDLE);
    add(5, C_START, 0, 0, 0, O_RUN);
    add(5, 0, 0, 0, 0, O_DTICK);
    add(5, 0, 0, 0, 0, O_DONE);
    add(5, C_CLR, 0, 0, 0, O_IDLE);
    add(5, C_START | C_PER, 15, 0, 0, O_RUN);
    for (int k = 1; k <= 17; k++) add(5, 0, 15, 0, 4'(k % 16), (k == 16) ? O_RTICK : O_RUN);
    add(5, C_CLR, 0, 0, 0, O_IDLE);
    add(5, C_START | C_PER, 9, 0, 0, O_RUN);
    add(5, 0, 9, 0, 1, O_RUN);
    add(5, 0, 9, 0, 2, O_RUN);
    add(5, C_RST, 9, 0, 0, O_IDLE);
    add(5, 0, 9, 0, 0, O_IDLE);
`ifdef CNT_SEQ_PRESCALE_EN
    // 6: divide by 3, term 1; prescaler frozen across a pause
    add(6, C_START | C_PER, 1, 2, 0, O_RUN);
    for (int k = 1; k <= 4; k++) add(6, 0, 1, 2, 4'((k / 3) % 2), (k % 6 == 0) ? O_RTICK : O_RUN);
    add(6, C_STOP, 1, 2, 1, O_RUN);
    add(6, 0, 1, 2, 1, O_RUN);
    add(6, 0, 1, 2, 1, O_RUN);
    add(6, C_START, 1, 2, 1, O_RUN);
    for (int k = 5; k <= 12; k++) add(6, 0, 1, 2, 4'((k / 3) % 2), (k % 6 == 0) ? O_RTICK : O_RUN);
    add(6, C_CLR, 0, 0, 0, O_IDLE);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctl, vecs[i].ld, vecs[i].pd);
      exp_q.push_back({vecs[i].ec, vecs[i].bte});
      @(posedge clk);
      #1;
      act = {bus.cnt, bus.busy, bus.tick, bus.done};
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL vec %0d: expectation queue empty", i);
      end else begin
        exp = exp_q.pop_front();
        if (act == exp) n_pass++;
        else $display("FAIL vec %0d (test %0d): cnt/busy/tick/done got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                      i, vecs[i].id, act[6:3], act[2], act[1], act[0],
                      exp[6:3], exp[2], exp[1], exp[0]);
      end
    end

    // Tick spacing for periodic term 2: first at start+3, then every 3 cycles.
    drive(C_START | C_PER, 2, 0);
    @(posedge clk);
    #1;
    drive(0, 2, 0);
    ntk = 0;
    for (int c = 1; c <= 20 && ntk < 3; c++) begin
      @(posedge clk);
      #1;
      if (bus.tick) begin
        tk[ntk] = c;
        ntk++;
      end
    end
    check("period_tick_count", ntk, 3);
    if (ntk == 3) begin
      check("period_first_tick", tk[0], 3);
      check("period_gap1", tk[1] - tk[0], 3);
      check("period_gap2", tk[2] - tk[1], 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
